abs_rtan_sweep: RTL and testbench
=================================

ABS_RTAN_SWEEP -- requirements
Module: abs_rtan_sweep

Interface
REQ-001 SHALL have parameter R_WIDTH, default 9: width of signed input r.
REQ-002 SHALL have parameter OUT_WIDTH, default 8: width of unsigned result.
REQ-003 SHALL have parameter NUM_ANGLES, default 6: number of angles swept (0, 15, ..., 15*(NUM_ANGLES-1) deg); legal range 1..6.
REQ-004 SHALL have parameter FRAC_BITS, default 8: fractional bits of the tan constants.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 Ports:
  clk        in   1          system clock, rising edge
  reset      in   1          synchronous, active-high reset
  start      in   1          request; sampled only in IDLE
  r          in   R_WIDTH    signed two's-complement radius; latched on accepted start
  busy       out  1          high from the accept cycle+1 through the DONE cycle
  out_valid  out  1          out_idx/out_value valid this cycle
  out_idx    out  3          angle index k (angle = 15*k deg)
  out_value  out  OUT_WIDTH  saturated |r|*tan(15k deg)
  out_sat    out  1          out_value was clipped this cycle
  done       out  1          one-cycle pulse, coincident with last out_valid
  any_sat    out  1          sticky: some result in current sweep clipped; cleared on next accepted start

Function
REQ-007 SHALL implement FSM IDLE -> ABS -> SWEEP -> DONE -> IDLE.
REQ-008 IDLE: start=1 latches r, clears any_sat, moves to ABS; start otherwise ignored, including while busy.
REQ-009 ABS (1 cycle): mag = |r| as unsigned R_WIDTH bits; r = -2^(R_WIDTH-1) SHALL yield 2^(R_WIDTH-1) without overflow.
REQ-010 SWEEP: one angle per cycle, k = 0..NUM_ANGLES-1 in order, out_valid=1 each cycle, no gaps.
REQ-011 Per angle: value = (mag * TAN[k] + 2^(FRAC_BITS-1)) >> FRAC_BITS (round half up), product width R_WIDTH+12 bits, no intermediate truncation.
REQ-012 If value > 2^OUT_WIDTH-1: out_value = 2^OUT_WIDTH-1, out_sat=1, any_sat set; else out_value = value[OUT_WIDTH-1:0], out_sat=0.
REQ-013 TAN constants (unsigned 12-bit, FRAC_BITS=8): k0=0, k1=69, k2=148, k3=256, k4=443, k5=955; for other FRAC_BITS, round(tan*2^FRAC_BITS).
REQ-014 90 deg SHALL NOT be computed.
REQ-015 done=1 in the cycle k=NUM_ANGLES-1 is presented; FSM then enters DONE for one cycle (busy=1, out_valid=0), then IDLE.
REQ-016 Latency: start accepted at cycle 0 -> k=0 result at cycle 2, last at cycle NUM_ANGLES+1; next start accepted no earlier than cycle NUM_ANGLES+3.
REQ-017 Outputs registered; out_idx/out_value/out_sat hold last values when out_valid=0; any_sat holds until next accepted start.

Reset
REQ-018 Reset SHALL force IDLE and busy, out_valid, done, out_sat, any_sat = 0, out_idx = 0, out_value = 0, latched r and mag = 0.
REQ-019 Reset asserted mid-sweep SHALL abort with no further out_valid or done; start in the reset cycle is ignored.

Structure
REQ-020 Package abs_rtan_pkg SHALL hold the FSM state encoding, the 12-bit TAN constant table, and the angle-step constant (15).
REQ-021 Sub-module rtan_const_rom (combinational, index k -> TAN[k]) SHALL supply constants; multiply, round and saturate stay in abs_rtan_sweep.

Verification
REQ-022 r=100, start -> k0..k5 = 0, 27, 58, 100, 173, 255; out_sat only on k5; any_sat=1; done with k5 at cycle 7.
REQ-023 r=-100 -> identical outputs to r=100.
REQ-024 r=-256 -> 0, 69, 148, 255(sat), 255(sat), 255(sat); no overflow in ABS.
REQ-025 r=0 -> six zeros, any_sat=0; start re-pulsed at cycles 1..7 ignored, single done.
REQ-026 reset at cycle 4 of r=100 sweep -> all outputs 0 next cycle, no done; new start afterwards yields full correct sweep.
REQ-027 NUM_ANGLES=3 build, r=200 -> 0, 54, 116; done with k2 at cycle 4.

Source files
------------

// File: rtl/abs_rtan_pkg.sv
// Shared definitions for the |r|*tan(15k deg) sweep: FSM encoding, tangent table, angle step.
// Latency: n/a (constants and elaboration-time helper only).
// Backpressure: n/a.
package abs_rtan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ABS   = 2'd1,
      ST_SWEEP = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int ANGLE_STEP_DEG = 15;
   localparam int MAX_ANGLES     = 6;
   localparam int TAN_W          = 12;
   localparam int TAN_REF_FRAC   = 8;

   // tan(15k deg) rounded to 8 fractional bits, k = 0..5 (90 deg deliberately absent)
   localparam logic [TAN_W-1:0] TAN_Q8 [MAX_ANGLES] =
      '{12'd0, 12'd69, 12'd148, 12'd256, 12'd443, 12'd955};

   // Same angles at 24 fractional bits, used to derive tables for other FRAC_BITS
   localparam logic [31:0] TAN_Q24 [MAX_ANGLES] =
      '{32'd0, 32'd4495442, 32'd9686330, 32'd16777216, 32'd29058991, 32'd62613423};

   // round(tan(15k deg) * 2^frac), truncated to the 12-bit table width; frac legal 1..23
   function automatic logic [TAN_W-1:0] tan_const(input int k, input int frac);
      logic [31:0]      scaled;
      logic [TAN_W-1:0] res;
      res    = '0;
      scaled = '0;
      if (k >= 0 && k < MAX_ANGLES) begin
         if (frac == TAN_REF_FRAC) begin
            res = TAN_Q8[k];
         end else if (frac >= 1 && frac <= 23) begin
            scaled = (TAN_Q24[k] + (32'd1 << (23 - frac))) >> (24 - frac);
            res    = scaled[TAN_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rtan_const_rom.sv
// Tangent constant lookup: angle index k -> round(tan(15k deg) * 2^FRAC_BITS).
// Latency: combinational, zero cycles.
// Backpressure: none; indices above 5 return zero.
module rtan_const_rom
   import abs_rtan_pkg::*;
#(
   parameter int FRAC_BITS = 8
) (
   input  logic [2:0]       k_i,
   output logic [TAN_W-1:0] tan_o
);

   localparam logic [TAN_W-1:0] TAN0 = tan_const(0, FRAC_BITS);
   localparam logic [TAN_W-1:0] TAN1 = tan_const(1, FRAC_BITS);
   localparam logic [TAN_W-1:0] TAN2 = tan_const(2, FRAC_BITS);
   localparam logic [TAN_W-1:0] TAN3 = tan_const(3, FRAC_BITS);
   localparam logic [TAN_W-1:0] TAN4 = tan_const(4, FRAC_BITS);
   localparam logic [TAN_W-1:0] TAN5 = tan_const(5, FRAC_BITS);

   // table select; out-of-range index yields 0
   always_comb begin
      tan_o = '0;
      case (k_i)
         3'd0:    tan_o = TAN0;
         3'd1:    tan_o = TAN1;
         3'd2:    tan_o = TAN2;
         3'd3:    tan_o = TAN3;
         3'd4:    tan_o = TAN4;
         3'd5:    tan_o = TAN5;
         default: tan_o = '0;
      endcase
   end

endmodule

// File: rtl/abs_rtan_sweep.sv
// Sweeps |r|*tan(15k deg), k = 0..NUM_ANGLES-1, one rounded/saturated result per cycle.
// Latency: start accepted at cycle 0 -> k=0 at cycle 2, last (with done) at cycle NUM_ANGLES+1.
// Backpressure: none; start is ignored outside IDLE, results cannot be stalled.
module abs_rtan_sweep
   import abs_rtan_pkg::*;
#(
   parameter int R_WIDTH    = 9,
   parameter int OUT_WIDTH  = 8,
   parameter int NUM_ANGLES = 6,
   parameter int FRAC_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [R_WIDTH-1:0]   r,
   output logic                 busy,
   output logic                 out_valid,
   output logic [2:0]           out_idx,
   output logic [OUT_WIDTH-1:0] out_value,
   output logic                 out_sat,
   output logic                 done,
   output logic                 any_sat
);

   // product keeps every bit: R_WIDTH magnitude times 12-bit constant
   localparam int                  PROD_W  = R_WIDTH + TAN_W;
   localparam logic [2:0]          LAST_K  = 3'(NUM_ANGLES - 1);
   localparam logic [PROD_W-1:0]   HALF    = PROD_W'(64'd1 << (FRAC_BITS - 1));
   localparam logic [PROD_W-1:0]   OUT_MAX = PROD_W'((64'd1 << OUT_WIDTH) - 64'd1);

   state_t                 state_q, state_d;
   logic [R_WIDTH-1:0]     r_q, r_d;
   logic [R_WIDTH-1:0]     mag_q, mag_d;
   logic [2:0]             k_q, k_d;
   logic                   busy_q, busy_d;
   logic                   valid_q, valid_d;
   logic [2:0]             idx_q, idx_d;
   logic [OUT_WIDTH-1:0]   value_q, value_d;
   logic                   sat_q, sat_d;
   logic                   done_q, done_d;
   logic                   any_sat_q, any_sat_d;

   logic [R_WIDTH-1:0]     abs_r;
   logic [R_WIDTH-1:0]     sel_mag;
   logic [2:0]             sel_k;
   logic [TAN_W-1:0]       tan_k;
   logic [PROD_W-1:0]      prod;
   logic [PROD_W-1:0]      scaled;
   logic                   over;
   logic                   load;

   // constant for the angle about to be presented
   rtan_const_rom #(.FRAC_BITS(FRAC_BITS)) u_rom (
      .k_i   (sel_k),
      .tan_o (tan_k)
   );

   // magnitude of the latched radius; the most negative value maps to 2^(R_WIDTH-1) unsigned
   always_comb begin
      abs_r = r_q;
      if (r_q[R_WIDTH-1]) abs_r = ~r_q + R_WIDTH'(1);
   end

   // full-width multiply, round half up, drop fraction, detect clipping
   always_comb begin
      prod   = PROD_W'(sel_mag) * PROD_W'(tan_k);
      scaled = (prod + HALF) >> FRAC_BITS;
      over   = (scaled > OUT_MAX);
   end

   // next state: results are computed one cycle ahead so they appear registered in SWEEP
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      mag_d     = mag_q;
      k_d       = k_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      idx_d     = idx_q;
      value_d   = value_q;
      sat_d     = sat_q;
      any_sat_d = any_sat_q;
      sel_k     = 3'd0;
      sel_mag   = mag_q;
      load      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               r_d       = r;
               any_sat_d = 1'b0;
               state_d   = ST_ABS;
            end
         end
         ST_ABS: begin
            mag_d   = abs_r;
            sel_mag = abs_r;
            sel_k   = 3'd0;
            load    = 1'b1;
            state_d = ST_SWEEP;
         end
         ST_SWEEP: begin
            if (k_q == LAST_K) begin
               state_d = ST_DONE;
            end else begin
               sel_k = k_q + 3'd1;
               load  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load) begin
         valid_d   = 1'b1;
         k_d       = sel_k;
         idx_d     = sel_k;
         done_d    = (sel_k == LAST_K);
         sat_d     = over;
         any_sat_d = any_sat_q | over;
         value_d   = over ? {OUT_WIDTH{1'b1}} : scaled[OUT_WIDTH-1:0];
      end
   end

   always_comb busy_d = (state_d != ST_IDLE);

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         r_q       <= '0;
         mag_q     <= '0;
         k_q       <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         value_q   <= '0;
         sat_q     <= 1'b0;
         done_q    <= 1'b0;
         any_sat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         mag_q     <= mag_d;
         k_q       <= k_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         value_q   <= value_d;
         sat_q     <= sat_d;
         done_q    <= done_d;
         any_sat_q <= any_sat_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign out_idx   = idx_q;
   assign out_value = value_q;
   assign out_sat   = sat_q;
   assign done      = done_q;
   assign any_sat   = any_sat_q;

endmodule

// File: tb/tb_abs_rtan_sweep.sv
// Bench for abs_rtan_sweep: default 6-angle build plus a 3-angle build sharing clock and reset.
// Expected results come from |r|*tan table arithmetic with round-half-up and clipping at 255.
// Outputs sampled 1 time unit after each rising edge, inputs driven at the same point.
module tb_abs_rtan_sweep;

   logic       clk;
   logic       reset;

   logic       start6, start3;
   logic [8:0] r6, r3;
   logic       busy6, valid6, sat6, done6, any6;
   logic       busy3, valid3, sat3, done3, any3;
   logic [2:0] idx6, idx3;
   logic [7:0] val6, val3;

   int checks = 0;
   int errors = 0;

   int TAN_TAB [6] = '{0, 69, 148, 256, 443, 955};

   // values the outputs should hold while out_valid is low, per build (0 = 6-angle, 1 = 3-angle)
   logic [2:0] hold_idx [2];
   logic [7:0] hold_val [2];
   logic       hold_sat [2];

   abs_rtan_sweep dut (
      .clk(clk), .reset(reset), .start(start6), .r(r6),
      .busy(busy6), .out_valid(valid6), .out_idx(idx6), .out_value(val6),
      .out_sat(sat6), .done(done6), .any_sat(any6)
   );

   abs_rtan_sweep #(.NUM_ANGLES(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .r(r3),
      .busy(busy3), .out_valid(valid3), .out_idx(idx3), .out_value(val3),
      .out_sat(sat3), .done(done3), .any_sat(any3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string step, input int b,
                             input logic eb, input logic ev, input logic ed,
                             input logic es, input logic ea,
                             input logic [2:0] ei, input logic [7:0] eval);
      logic ob, ov, od, os, oa;
      logic [2:0] oi;
      logic [7:0] oval;
      if (b == 1) begin
         ob = busy3; ov = valid3; od = done3; os = sat3; oa = any3; oi = idx3; oval = val3;
      end else begin
         ob = busy6; ov = valid6; od = done6; os = sat6; oa = any6; oi = idx6; oval = val6;
      end
      chk({step, ".busy"},      32'(ob),   32'(eb));
      chk({step, ".out_valid"}, 32'(ov),   32'(ev));
      chk({step, ".done"},      32'(od),   32'(ed));
      chk({step, ".out_sat"},   32'(os),   32'(es));
      chk({step, ".any_sat"},   32'(oa),   32'(ea));
      chk({step, ".out_idx"},   32'(oi),   32'(ei));
      chk({step, ".out_value"}, 32'(oval), 32'(eval));
   endtask

   task automatic drive(input int b, input logic s, input logic [8:0] rv);
      if (b == 1) begin start3 = s; r3 = rv; end
      else        begin start6 = s; r6 = rv; end
   endtask

   // one complete sweep from IDLE; optionally keeps start high through every result cycle
   task automatic do_sweep(input string name, input int rv, input int b, input int n,
                           input bit hold_start);
      int         mag;
      int         v;
      logic       acc;
      logic       s;
      logic [8:0] rb;
      logic [7:0] ov;
      rb  = rv[8:0];
      mag = (rv < 0) ? -rv : rv;
      acc = 1'b0;
      drive(b, 1'b1, rb);
      tick();
      // latched copy must be used, so disturb the input bus
      drive(b, hold_start, ~rb);
      expect_out($sformatf("%s.c1", name), b, 1'b1, 1'b0, 1'b0,
                 hold_sat[b], 1'b0, hold_idx[b], hold_val[b]);
      for (int k = 0; k < n; k++) begin
         tick();
         v   = (mag * TAN_TAB[k] + 128) / 256;
         s   = (v > 255);
         ov  = s ? 8'd255 : 8'(v);
         acc = acc | s;
         expect_out($sformatf("%s.k%0d", name, k), b, 1'b1, 1'b1, (k == n - 1),
                    s, acc, 3'(k), ov);
         hold_idx[b] = 3'(k);
         hold_val[b] = ov;
         hold_sat[b] = s;
      end
      drive(b, 1'b0, ~rb);
      tick();
      expect_out($sformatf("%s.done_state", name), b, 1'b1, 1'b0, 1'b0,
                 hold_sat[b], acc, hold_idx[b], hold_val[b]);
      tick();
      expect_out($sformatf("%s.idle", name), b, 1'b0, 1'b0, 1'b0,
                 hold_sat[b], acc, hold_idx[b], hold_val[b]);
      tick();
      expect_out($sformatf("%s.idle2", name), b, 1'b0, 1'b0, 1'b0,
                 hold_sat[b], acc, hold_idx[b], hold_val[b]);
   endtask

   initial begin
      int rv;
      reset  = 1'b1;
      start6 = 1'b1;
      start3 = 1'b1;
      r6     = 9'd77;
      r3     = 9'd77;
      for (int i = 0; i < 2; i++) begin
         hold_idx[i] = 3'd0;
         hold_val[i] = 8'd0;
         hold_sat[i] = 1'b0;
      end

      // reset state, with start asserted during reset
      tick();
      tick();
      expect_out("reset6", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      expect_out("reset3", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      start6 = 1'b0;
      start3 = 1'b0;
      reset  = 1'b0;
      tick();
      expect_out("post_reset6", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);

      // directed sweeps on the 6-angle build
      do_sweep("r100",  100,  0, 6, 1'b0);
      do_sweep("rm100", -100, 0, 6, 1'b0);
      do_sweep("rm256", -256, 0, 6, 1'b0);
      do_sweep("r0",    0,    0, 6, 1'b1);
      do_sweep("r255",  255,  0, 6, 1'b0);
      do_sweep("rm1",   -1,   0, 6, 1'b0);

      // reset in the middle of an r=100 sweep, with start high in the reset cycle
      drive(0, 1'b1, 9'd100);
      tick();
      drive(0, 1'b0, 9'd0);
      tick();
      tick();
      tick();
      expect_out("abort.k2", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'd58);
      reset = 1'b1;
      drive(0, 1'b1, 9'd100);
      tick();
      reset = 1'b0;
      drive(0, 1'b0, 9'd0);
      hold_idx[0] = 3'd0;
      hold_val[0] = 8'd0;
      hold_sat[0] = 1'b0;
      hold_idx[1] = 3'd0;
      hold_val[1] = 8'd0;
      hold_sat[1] = 1'b0;
      expect_out("abort.reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      for (int c = 0; c < 8; c++) begin
         tick();
         expect_out($sformatf("abort.quiet%0d", c), 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    3'd0, 8'd0);
      end
      do_sweep("after_abort", 100, 0, 6, 1'b0);

      // 3-angle build
      do_sweep("n3_r200", 200, 1, 3, 1'b0);
      do_sweep("n3_rm256", -256, 1, 3, 1'b0);

      // randomized radii on both builds
      for (int t = 0; t < 12; t++) begin
         rv = int'($urandom_range(0, 511)) - 256;
         do_sweep($sformatf("rnd%0d", t), rv, t % 2, (t % 2 == 1) ? 3 : 6, t[2]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
